// File: rtl/mouse_pos_tracker.sv
// rtl/mouse_pos_tracker.sv - PS/2 mouse packet framer and clamped absolute cursor position
module mouse_pos_tracker #(
    parameter int XMAX        = 1023,
    parameter int YMAX        = 767,
    parameter int X_INIT      = 512,
    parameter int Y_INIT      = 384,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left_button,
    output logic        right_button,
    output logic        pkt_valid,
    output logic        sync_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0]     TO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [11:0]       XMAX_12   = 12'(XMAX);
    localparam logic [11:0]       YMAX_12   = 12'(YMAX);
    localparam logic [11:0]       X_INIT_12 = 12'(X_INIT);
    localparam logic [11:0]       Y_INIT_12 = 12'(Y_INIT);
    localparam logic signed [12:0] XMAX_S   = 13'(XMAX);
    localparam logic signed [12:0] YMAX_S   = 13'(YMAX);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } state_t;

    state_t             state;
    logic [7:0]         b0;
    logic [7:0]         b1;
    logic [CW-1:0]      idle_cnt;

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic signed [12:0] x_sum;
    logic signed [12:0] y_sum;
    logic [11:0]        x_clamped;
    logic [11:0]        y_clamped;

    // Candidate position from the latched header/x byte and the y byte currently on rx_data
    always_comb begin
        dx = '0;
        dy = '0;
        if (!b0[6]) begin
            dx = {{4{b0[4]}}, b0[4], b1};
        end
        if (!b0[7]) begin
            dy = {{4{b0[5]}}, b0[5], rx_data};
        end
        // Screen y grows downward, so a positive mouse dy moves the cursor up.
        x_sum = $signed({1'b0, xpos}) + dx;
        y_sum = $signed({1'b0, ypos}) - dy;

        x_clamped = x_sum[11:0];
        if (x_sum < 13'sd0) begin
            x_clamped = 12'd0;
        end else if (x_sum > XMAX_S) begin
            x_clamped = XMAX_12;
        end

        y_clamped = y_sum[11:0];
        if (y_sum < 13'sd0) begin
            y_clamped = 12'd0;
        end else if (y_sum > YMAX_S) begin
            y_clamped = YMAX_12;
        end
    end

    // Packet framing FSM with mid-packet idle timeout and registered position/button outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_B0;
            b0           <= '0;
            b1           <= '0;
            idle_cnt     <= '0;
            xpos         <= X_INIT_12;
            ypos         <= Y_INIT_12;
            left_button  <= 1'b0;
            right_button <= 1'b0;
            pkt_valid    <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            case (state)
                WAIT_B0: begin
                    idle_cnt <= '0;
                    if (rx_valid) begin
                        // Bit 3 is always set in a valid header; anything else means we are misaligned.
                        if (rx_data[3]) begin
                            b0    <= rx_data;
                            state <= WAIT_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (rx_valid) begin
                        b1       <= rx_data;
                        idle_cnt <= '0;
                        state    <= WAIT_B2;
                    end else if (idle_cnt == TO_LAST) begin
                        idle_cnt <= '0;
                        sync_err <= 1'b1;
                        state    <= WAIT_B0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                WAIT_B2: begin
                    // A byte arriving on the expiry cycle takes precedence over the timeout.
                    if (rx_valid) begin
                        xpos         <= x_clamped;
                        ypos         <= y_clamped;
                        left_button  <= b0[0];
                        right_button <= b0[1];
                        pkt_valid    <= 1'b1;
                        idle_cnt     <= '0;
                        state        <= WAIT_B0;
                    end else if (idle_cnt == TO_LAST) begin
                        idle_cnt <= '0;
                        sync_err <= 1'b1;
                        state    <= WAIT_B0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                default: begin
                    idle_cnt <= '0;
                    state    <= WAIT_B0;
                end
            endcase
        end
    end

endmodule

// File: doc/mouse_pos_tracker.md
Name: mouse_pos_tracker

Overview:
- Upstream of the menu/map screen-select control.
- Consumes the PS/2 mouse byte stream from the PS/2 receiver (one strobed byte at a time) and frames 3-byte standard mouse packets.
- Integrates signed deltas into an absolute, clamped 1024x768 screen position.
- Supplies xpos/ypos/left_button to the screen-select control and the cursor overlay.
- Runs in the 65 MHz pixel clock domain.

Parameters:
XMAX, 1023, largest legal x coordinate
YMAX, 767, largest legal y coordinate
X_INIT, 512, x position after reset
Y_INIT, 384, y position after reset
TIMEOUT_CYC, 131072, idle cycles mid-packet before the partial packet is dropped (~2 ms @ 65 MHz)

Ports:
clk  input  1  system clock (65 MHz)
rst  input  1  synchronous, active-high reset
rx_data  input  8  received PS/2 byte; valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe, one byte per strobe, never two consecutive bytes in the same cycle
xpos  output  12  absolute cursor x, 0..XMAX
ypos  output  12  absolute cursor y, 0..YMAX, 0 = top of screen
left_button  output  1  left button state from last good packet
right_button  output  1  right button state from last good packet
pkt_valid  output  1  one-cycle pulse: position/buttons updated this cycle
sync_err  output  1  one-cycle pulse: byte discarded or partial packet dropped

Behaviour:
Reset (rst=1 at a clk edge), taking priority over everything:
- xpos=X_INIT, ypos=Y_INIT.
- left_button=0, right_button=0, pkt_valid=0, sync_err=0.
- FSM goes to WAIT_B0, timeout counter cleared, any partial packet discarded.
- Reset asserted mid-packet: the following bytes are framed from scratch.

FSM states: WAIT_B0, WAIT_B1, WAIT_B2.
- WAIT_B0, rx_valid and rx_data[3]=1: latch as b0, go to WAIT_B1.
- WAIT_B0, rx_valid and rx_data[3]=0: discard byte, pulse sync_err, stay in WAIT_B0 (resync).
- WAIT_B1, rx_valid: latch b1, go to WAIT_B2.
- WAIT_B2, rx_valid: latch b2 and apply the update; go to WAIT_B0.

Timeout:
- The counter runs only in WAIT_B1/WAIT_B2 and clears on every accepted byte.
- If TIMEOUT_CYC consecutive cycles pass without rx_valid, go to WAIT_B0, pulse sync_err, discard b0/b1; outputs are unchanged.
- rx_valid in the same cycle the timeout would expire: the byte wins and is processed normally, with no sync_err.

Update (registered at the edge that samples the third byte; visible the next cycle together with pkt_valid=1 for exactly one cycle):
- dx = 9-bit signed {b0[4], b1}; dy = 9-bit signed {b0[5], b2}.
- b0[6] (x overflow) set: dx treated as 0. b0[7] (y overflow) set: dy treated as 0. Buttons still update.
- Arithmetic in 13-bit signed: x_new = xpos + dx; y_new = ypos - dy (mouse up = screen up).
- Clamp each axis independently: result <0 gives 0; result >XMAX/YMAX gives XMAX/YMAX. No wrap-around.
- left_button=b0[0], right_button=b0[1].
- Between packets, all position/button outputs hold.
- pkt_valid and sync_err are never asserted in the same cycle. They default to 0 every cycle.

Test Plan:
- Reset, then packet 0x08,0x10,0x05 -> one cycle after 3rd strobe: xpos=528, ypos=379, left_button=0, pkt_valid=1 for one cycle.
- From reset, packet 0x09,0x00,0x00 then 0x08,0x00,0x00 -> left_button 1 after first packet, 0 after second; position stays 512/384.
- Clamp: from reset, send 0x18,0x00,0x00 (dx=-256) three times -> xpos 256, 0, 0. Send 0x28,0x00,0x00 (dy=-256) twice -> ypos 640, 767.
- Resync: stream 0x05 then 0x08,0x04,0x00 -> sync_err pulse on 0x05; xpos=516, exactly one pkt_valid.
- Timeout: send 0x08,0x7F, idle TIMEOUT_CYC cycles -> sync_err pulse, no pkt_valid. Then 0x08,0x01,0x01 -> xpos=513, ypos=383. Repeat with the 3rd byte arriving at the expiry cycle -> accepted, no sync_err.
- Overflow plus mid-packet reset: 0x48,0xFF,0x02 -> xpos unchanged, ypos -=2. Separately, rst after 2 bytes, then 0x08,0x02,0x00 -> xpos=514, ypos=384.
